// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, BCD constants and clamp helper for the countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the system clock down to a one-cycle tick
// The count holds while enable is low, so a paused period resumes where it left off.
module tick_prescaler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int LP_TERM = CLK_HZ / TICK_HZ - 1;
  localparam int LP_W    = (LP_TERM > 0) ? $clog2(LP_TERM + 1) : 1;
  localparam logic [LP_W-1:0] LP_TERM_V = LP_W'(LP_TERM);

  logic [LP_W-1:0] r_cnt;
  logic            w_term;

  assign w_term = (r_cnt == LP_TERM_V);
  assign tick   = enable & ~clear & w_term;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_units_countdown.sv
// rtl/bcd_units_countdown.sv - units-digit BCD down-counter with run/pause/done control and borrow to the tens stage
// AUTO_RESTART_EN: when defined, the all-zero condition reloads and keeps running instead of entering DONE.
module bcd_units_countdown
  import timer_pkg::*;
#(
  parameter int         CLK_HZ     = 50000000,
  parameter int         TICK_HZ    = 1,
  parameter logic [3:0] RELOAD_VAL = 4'd9
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       tens_zero,
  output logic [3:0] bcd,
  output logic       borrow,
  output logic       tick,
  output logic       done
);

  localparam logic [3:0] LP_RELOAD = bcd_clamp(RELOAD_VAL);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bcd, w_bcd_nxt;
  logic       r_borrow, w_borrow_nxt;
  logic       r_done, w_done_nxt;
  logic       r_tick;
  logic       w_presc_tick, w_presc_clear, w_presc_en;
  logic       w_resume;

  // Pause gates the prescaler in the same cycle, so a coincident tick is held, not lost.
  assign w_presc_clear = load | (r_state == ST_IDLE);
  assign w_presc_en    = (r_state == ST_RUN) & ~pause & ~load;
  assign w_resume      = start & ~pause;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (w_presc_clear),
    .enable (w_presc_en),
    .tick   (w_presc_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_resume) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_presc_tick && (r_bcd == BCD_ZERO) && tens_zero) begin
`ifdef AUTO_RESTART_EN
            w_state_nxt = ST_RUN;
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end
        ST_PAUSED: if (w_resume) w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_DONE;
      endcase
    end
  end

  always_comb begin
    w_bcd_nxt    = r_bcd;
    w_borrow_nxt = 1'b0;
    w_done_nxt   = (r_state == ST_DONE);
    if (load) begin
      w_bcd_nxt  = bcd_clamp(load_val);
      w_done_nxt = 1'b0;
    end else if (w_presc_tick) begin
      if (r_bcd != BCD_ZERO) begin
        w_bcd_nxt = r_bcd - 4'd1;
      end else if (!tens_zero) begin
        w_bcd_nxt    = LP_RELOAD;
        w_borrow_nxt = 1'b1;
      end else begin
`ifdef AUTO_RESTART_EN
        w_bcd_nxt    = LP_RELOAD;
        w_borrow_nxt = 1'b1;
        w_done_nxt   = 1'b1;
`else
        w_done_nxt   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd    <= BCD_ZERO;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_bcd    <= w_bcd_nxt;
      r_borrow <= w_borrow_nxt;
      r_done   <= w_done_nxt;
      r_tick   <= w_presc_tick;
    end
  end

  assign bcd    = r_bcd;
  assign borrow = r_borrow;
  assign done   = r_done;
  assign tick   = r_tick;

endmodule
